// File: rtl/enc_binder_bank_pkg.sv
// enc_binder_bank_pkg: shared encoder constants, per-channel shift table and FSM state type.
package enc_binder_bank_pkg;
  localparam int HV_DIM = 16;
  localparam int SHIFT_W = $clog2(HV_DIM);
  localparam int SHIFTS_LEN = 12;
  localparam int SHIFTS [SHIFTS_LEN] = '{1, 2, 3, 0, 15, 5, 7, 11, 4, 9, 13, 6};
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int shift_mod(input int idx, input int dim);
    return SHIFTS[idx] % dim;
  endfunction
endpackage

// File: rtl/enc_rotator.sv
// enc_rotator: combinational cyclic rotate; dir=0 rotates left (bind), dir=1 rotates right (unbind).
module enc_rotator
  import enc_binder_bank_pkg::*;
#(
  parameter int DIM = HV_DIM,
  parameter int SW = SHIFT_W
) (
  input  logic [DIM-1:0] din,
  input  logic [SW-1:0]  shift,
  input  logic           dir,
  output logic [DIM-1:0] dout
);
  logic [2*DIM-1:0] dbl;
  logic [SW:0] ls;
  logic [SW:0] rs;
  assign dbl = {din, din};
  // a left rotate by s is the window starting DIM-s into the doubled word
  assign ls = (SW+1)'(DIM) - {1'b0, shift};
  assign rs = {1'b0, shift};
  assign dout = dir ? dbl[rs +: DIM] : dbl[ls +: DIM];
endmodule

// File: rtl/enc_binder_bank.sv
// enc_binder_bank: time-multiplexed binder, LANES rotators sweep NUM_CH channels in ceil(NUM_CH/LANES) cycles.
module enc_binder_bank
  import enc_binder_bank_pkg::*;
#(
  parameter int HV_DIM = enc_binder_bank_pkg::HV_DIM,
  parameter int NUM_CH = 10,
  parameter int LANES = 2,
  parameter int BASE_IDX = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  input  logic              unbind,
  input  logic [HV_DIM-1:0] level_hv [NUM_CH],
  output logic              busy,
  output logic              done,
  output logic [HV_DIM-1:0] shifted_hv [NUM_CH]
);
  localparam int NB = (NUM_CH + LANES - 1) / LANES;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int SW = HV_DIM > 1 ? $clog2(HV_DIM) : 1;
  localparam int PAD = NB * LANES;
  localparam int CW = PAD > 1 ? $clog2(PAD) : 1;

  if (BASE_IDX + NUM_CH > SHIFTS_LEN) begin : g_tbl_chk
    $error("enc_binder_bank: BASE_IDX+NUM_CH exceeds SHIFTS table");
  end
  if (LANES < 1 || LANES > NUM_CH) begin : g_lane_chk
    $error("enc_binder_bank: LANES must be in 1..NUM_CH");
  end

  state_t state;
  logic [BW-1:0] bcnt;
  logic mode;
  logic done_q;
  logic [HV_DIM-1:0] lvl [PAD];
  logic [SW-1:0] rom [PAD];
  logic [HV_DIM-1:0] rot [LANES];

  // padded slots belong to idle lanes of the last batch; their results are never stored
  for (genvar i = 0; i < PAD; i++) begin : g_pad
    if (i < NUM_CH) begin : g_ch
      assign lvl[i] = level_hv[i];
      assign rom[i] = SW'(shift_mod(BASE_IDX + i, HV_DIM));
    end else begin : g_idle
      assign lvl[i] = '0;
      assign rom[i] = '0;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CW-1:0] ch;
    assign ch = CW'(int'(bcnt) * LANES + l);
    enc_rotator #(.DIM(HV_DIM), .SW(SW)) u_rot (
      .din(lvl[ch]),
      .shift(rom[ch]),
      .dir(mode),
      .dout(rot[l])
    );
  end

  assign busy = state == RUN;
  assign done = done_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      bcnt <= '0;
      mode <= 1'b0;
      done_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) shifted_hv[c] <= '0;
    end else begin
      done_q <= state == RUN && bcnt == BW'(NB - 1);
      if (state == IDLE) begin
        if (start_encoding) begin
          state <= RUN;
          bcnt <= '0;
          mode <= unbind;
        end
      end else begin
        for (int c = 0; c < NUM_CH; c++)
          if (bcnt == BW'(c / LANES)) shifted_hv[c] <= rot[c % LANES];
        bcnt <= bcnt == BW'(NB - 1) ? '0 : bcnt + 1'b1;
        state <= bcnt == BW'(NB - 1) ? IDLE : RUN;
      end
    end
  end
endmodule
